// File: rtl/avalon_mm_arb_pkg.sv
// Shared types for the Avalon-MM round-robin arbiter: FSM states and read tags.
package avalon_mm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD      = 2'd1,
    ST_WR_BURST = 2'd2
  } arb_state_e;

  // Tag fields are sized for the default arbiter configuration.
  localparam int unsigned ARB_NUM_MASTERS = 4;
  localparam int unsigned ARB_ID_W        = $clog2(ARB_NUM_MASTERS);
  localparam int unsigned ARB_LEN_W       = 8;

  typedef struct packed {
    logic [ARB_ID_W-1:0]  id;
    logic [ARB_LEN_W-1:0] len;
  } rd_tag_t;

  localparam int unsigned RD_TAG_W = $bits(rd_tag_t);

endpackage

// File: rtl/rd_tag_fifo.sv
// Synchronous FIFO of outstanding read tags; push and pop may share a cycle even when full.
module rd_tag_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter.sv
// Round-robin, burst-aware arbiter sharing one Avalon-MM slave between several masters.
module avalon_mm_arbiter
  import avalon_mm_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS       = 4,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned DATA_WIDTH        = 64,
  parameter int unsigned BURST_COUNT_WIDTH = 8,
  parameter int unsigned BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned MAX_PENDING_READS = 8
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]            m_address,
  input  logic [NUM_MASTERS-1:0][BURST_COUNT_WIDTH-1:0]     m_burstcount,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]            m_writedata,
  input  logic [NUM_MASTERS-1:0][BYTE_ENABLE_WIDTH-1:0]     m_byteenable,
  input  logic [NUM_MASTERS-1:0]                            m_read,
  input  logic [NUM_MASTERS-1:0]                            m_write,
  output logic [NUM_MASTERS-1:0]                            m_waitrequest,
  output logic [DATA_WIDTH-1:0]                             m_readdata,
  output logic [NUM_MASTERS-1:0]                            m_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                             s_address,
  output logic [BURST_COUNT_WIDTH-1:0]                      s_burstcount,
  output logic [DATA_WIDTH-1:0]                             s_writedata,
  output logic [BYTE_ENABLE_WIDTH-1:0]                      s_byteenable,
  output logic                                              s_read,
  output logic                                              s_write,
  input  logic                                              s_waitrequest,
  input  logic [DATA_WIDTH-1:0]                             s_readdata,
  input  logic                                              s_readdatavalid,
  output logic                                              err_unexpected_rdata
);

  localparam int unsigned ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned BC_W = BURST_COUNT_WIDTH;

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      rr_q, rr_d;
  logic [BC_W-1:0]      beats_q, beats_d;
  logic [ARB_LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                 err_q, err_d;

  logic [NUM_MASTERS-1:0] req;
  logic                   found;
  logic [ID_W-1:0]        win_id;
  int unsigned            idx;

  logic [BC_W-1:0]      g_bc;
  rd_tag_t              push_tag, head_tag;
  logic [RD_TAG_W-1:0]  head_bits;
  logic [ID_W-1:0]      head_id;
  logic                 tag_push, tag_pop, tag_full, tag_empty;

  // Burstcount of the granted master, with 0 treated as a single beat.
  assign g_bc = (m_burstcount[grant_q] == '0) ? BC_W'(1) : m_burstcount[grant_q];

  assign push_tag  = '{id: ARB_ID_W'(grant_q), len: ARB_LEN_W'(g_bc)};
  assign head_tag  = rd_tag_t'(head_bits);
  assign head_id   = ID_W'(head_tag.id);

  assign m_readdata           = s_readdata;
  assign err_unexpected_rdata = err_q;

  rd_tag_fifo #(
    .DEPTH (MAX_PENDING_READS),
    .WIDTH (RD_TAG_W)
  ) u_rd_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_push),
    .din_i   (push_tag),
    .pop_i   (tag_pop),
    .head_o  (head_bits),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  // Round-robin pick: first requester at or after rr_q, wrapping.
  always_comb begin
    req    = m_read | m_write;
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req[ID_W'(idx)]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  // Command-side FSM: arbitration, command forwarding, burst lock.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    beats_d       = beats_q;
    m_waitrequest = '1;
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_address     = '0;
    s_burstcount  = '0;
    s_writedata   = '0;
    s_byteenable  = '0;
    tag_push      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = win_id;
          rr_d    = (win_id == ID_W'(NUM_MASTERS - 1)) ? '0 : win_id + ID_W'(1);
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        s_address    = m_address[grant_q];
        s_burstcount = m_burstcount[grant_q];
        s_writedata  = m_writedata[grant_q];
        s_byteenable = m_byteenable[grant_q];
        if (m_write[grant_q]) begin
          s_write                = 1'b1;
          m_waitrequest[grant_q] = s_waitrequest;
          if (!s_waitrequest) begin
            if (g_bc == BC_W'(1)) begin
              state_d = ST_IDLE;
            end else begin
              beats_d = g_bc - BC_W'(1);
              state_d = ST_WR_BURST;
            end
          end
        end else if (m_read[grant_q]) begin
          // A full tag FIFO holds the read off the slave until a return frees a slot.
          if (!tag_full) begin
            s_read                 = 1'b1;
            m_waitrequest[grant_q] = s_waitrequest;
            if (!s_waitrequest) begin
              tag_push = 1'b1;
              state_d  = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_BURST: begin
        s_address              = m_address[grant_q];
        s_burstcount           = m_burstcount[grant_q];
        s_writedata            = m_writedata[grant_q];
        s_byteenable           = m_byteenable[grant_q];
        s_write                = m_write[grant_q];
        m_waitrequest[grant_q] = s_waitrequest;
        if (m_write[grant_q] && !s_waitrequest) begin
          if (beats_q == BC_W'(1)) begin
            state_d = ST_IDLE;
          end else begin
            beats_d = beats_q - BC_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Read return: steer each beat to the head tag's master, pop on its last beat.
  always_comb begin
    m_readdatavalid = '0;
    tag_pop         = 1'b0;
    rd_cnt_d        = rd_cnt_q;
    err_d           = err_q;
    if (s_readdatavalid) begin
      if (tag_empty) begin
        err_d = 1'b1;
      end else begin
        m_readdatavalid[head_id] = 1'b1;
        if (rd_cnt_q == head_tag.len - ARB_LEN_W'(1)) begin
          tag_pop  = 1'b1;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + ARB_LEN_W'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      beats_q  <= '0;
      rd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      beats_q  <= beats_d;
      rd_cnt_q <= rd_cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// Scoreboard bench for avalon_mm_arbiter: directed master traffic, slave model, decoupled monitor.
module tb_avalon_mm_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = 8;
  localparam int BEW = 8;
  localparam logic [63:0] RD_BASE = 64'hDA7A_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0]  m_address;
  logic [N-1:0][BW-1:0]  m_burstcount;
  logic [N-1:0][DW-1:0]  m_writedata;
  logic [N-1:0][BEW-1:0] m_byteenable;
  logic [N-1:0]          m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [DW-1:0]         m_readdata;
  logic [AW-1:0]         s_address;
  logic [BW-1:0]         s_burstcount;
  logic [DW-1:0]         s_writedata;
  logic [BEW-1:0]        s_byteenable;
  logic                  s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [DW-1:0]         s_readdata;
  logic                  err;

  avalon_mm_arbiter dut (
    .clk                  (clk),
    .rst                  (rst),
    .m_address            (m_address),
    .m_burstcount         (m_burstcount),
    .m_writedata          (m_writedata),
    .m_byteenable         (m_byteenable),
    .m_read               (m_read),
    .m_write              (m_write),
    .m_waitrequest        (m_waitrequest),
    .m_readdata           (m_readdata),
    .m_readdatavalid      (m_readdatavalid),
    .s_address            (s_address),
    .s_burstcount         (s_burstcount),
    .s_writedata          (s_writedata),
    .s_byteenable         (s_byteenable),
    .s_read               (s_read),
    .s_write              (s_write),
    .s_waitrequest        (s_waitrequest),
    .s_readdata           (s_readdata),
    .s_readdatavalid      (s_readdatavalid),
    .err_unexpected_rdata (err)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [63:0] data;
    int          cyc;
  } cmd_t;

  typedef struct {
    logic [3:0]  vld;
    logic [63:0] data;
  } rd_t;

  cmd_t exp_cmd[$];
  rd_t  exp_rd[$];
  int   pend[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rseq     = 0;
  int   exp_k    = 0;
  int   seen     = 0;
  int   c0       = 0;
  bit   ret_en   = 1'b1;
  bit   spur     = 1'b0;
  cmd_t mc;
  rd_t  mr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_cmd(input bit wr, input logic [31:0] a, input logic [7:0] bc,
                                   input logic [63:0] d, input int c);
    cmd_t e;
    e.wr = wr; e.addr = a; e.bc = bc; e.data = d; e.cyc = c;
    exp_cmd.push_back(e);
  endfunction

  function automatic void push_rd(input logic [3:0] vld);
    rd_t e;
    e.vld  = vld;
    e.data = RD_BASE + 64'(exp_k);
    exp_k++;
    exp_rd.push_back(e);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every slave-accepted command and every master read beat is checked in order.
  always @(negedge clk) begin
    if (!rst) begin
      if ((s_read || s_write) && !s_waitrequest) begin
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", 64'(1), 64'(0));
        end else begin
          mc = exp_cmd.pop_front();
          chk("cmd_kind", 64'(s_write), 64'(mc.wr));
          chk("cmd_addr", 64'(s_address), 64'(mc.addr));
          chk("cmd_bc", 64'(s_burstcount), 64'(mc.bc));
          if (mc.wr) chk("cmd_wdata", s_writedata, mc.data);
          if (mc.cyc >= 0) chk("cmd_cycle", 64'(cyc), 64'(mc.cyc));
        end
      end
      if (m_readdatavalid != '0) begin
        if (exp_rd.size() == 0) begin
          chk("rdv_unexpected", 64'(m_readdatavalid), 64'(0));
        end else begin
          mr = exp_rd.pop_front();
          chk("rdv_vec", 64'(m_readdatavalid), 64'(mr.vld));
          chk("rdata", m_readdata, mr.data);
        end
      end
    end
  end

  // Slave model: never stalls, returns accepted read bursts in order when enabled.
  initial begin
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b0;
    s_readdata      = '0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (s_read && !s_waitrequest) pend.push_back((s_burstcount == 0) ? 1 : int'(s_burstcount));
      @(posedge clk);
      #1;
      if (spur) begin
        s_readdatavalid = 1'b1;
        s_readdata      = 64'hBAD0;
      end else if (ret_en && !rst && pend.size() > 0) begin
        s_readdatavalid = 1'b1;
        s_readdata      = RD_BASE + 64'(rseq);
        rseq++;
        pend[0] = pend[0] - 1;
        if (pend[0] == 0) void'(pend.pop_front());
      end else begin
        s_readdatavalid = 1'b0;
        s_readdata      = '0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Master BFM: holds each beat until waitrequest drops, then moves on after the edge.
  task automatic mcmd(input int i, input bit rd, input logic [31:0] addr, input logic [7:0] bc,
                      input logic [63:0] d0);
    int beats;
    int t;
    beats = (rd || bc == 0) ? 1 : int'(bc);
    for (int b = 0; b < beats; b++) begin
      m_address[i]    = addr;
      m_burstcount[i] = bc;
      m_writedata[i]  = d0 + 64'(b);
      m_byteenable[i] = '1;
      m_read[i]       = rd;
      m_write[i]      = !rd;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (!m_waitrequest[i]) break;
        t++;
        if (t > 300) begin
          chk("bfm_timeout", 64'(1), 64'(0));
          m_read[i]  = 1'b0;
          m_write[i] = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    m_read[i]  = 1'b0;
    m_write[i] = 1'b0;
  endtask

  task automatic master_stream(input int i);
    for (int k = 0; k < 4; k++)
      mcmd(i, 1'b0, 32'h1000 + 32'(i) * 32'h100 + 32'(k) * 8, 8'd1, 64'hC0 + 64'(i * 16 + k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_address = '0; m_burstcount = '0; m_writedata = '0; m_byteenable = '0;
    m_read = '0; m_write = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waitreq", 64'(m_waitrequest), 64'hF);
    chk("rst_rdv", 64'(m_readdatavalid), 64'(0));
    chk("rst_s_rw", 64'({s_read, s_write}), 64'(0));
    chk("rst_s_addr", 64'(s_address), 64'(0));
    chk("rst_s_bc", 64'(s_burstcount), 64'(0));
    chk("rst_s_wdata", s_writedata, 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    @(posedge clk); #1; rst = 1'b0;

    // Masters 0 and 2 write together: 0 first, s_write in cycles 2 and 4
    c0 = cyc;
    push_cmd(1'b1, 32'h100, 8'd1, 64'hA0, c0 + 1);
    push_cmd(1'b1, 32'h200, 8'd1, 64'hA2, c0 + 3);
    fork
      mcmd(0, 1'b0, 32'h100, 8'd1, 64'hA0);
      mcmd(2, 1'b0, 32'h200, 8'd1, 64'hA2);
    join
    idle(2);

    // Master 1 write burst of 4 locks out master 3's read
    c0 = cyc;
    for (int b = 0; b < 4; b++) push_cmd(1'b1, 32'h300, 8'd4, 64'hB0 + 64'(b), c0 + 1 + b);
    push_cmd(1'b0, 32'h400, 8'd1, 64'h0, c0 + 6);
    push_rd(4'b1000);
    seen = 0;
    fork
      mcmd(1, 1'b0, 32'h300, 8'd4, 64'hB0);
      begin idle(1); mcmd(3, 1'b1, 32'h400, 8'd1, 64'h0); end
      begin
        for (int c = 0; c < 40 && seen < 4; c++) begin
          @(negedge clk);
          if (s_write) begin
            chk("m3_wait_in_burst", 64'(m_waitrequest[3]), 64'(1));
            chk("no_sread_in_burst", 64'(s_read), 64'(0));
            seen++;
          end
        end
        chk("burst_beats_seen", 64'(seen), 64'(4));
      end
    join
    idle(3);

    // Masters 0 and 1 read 2 beats each; returns steered in issue order
    c0 = cyc;
    push_cmd(1'b0, 32'h500, 8'd2, 64'h0, c0 + 1);
    push_cmd(1'b0, 32'h600, 8'd2, 64'h0, c0 + 3);
    push_rd(4'b0001); push_rd(4'b0001); push_rd(4'b0010); push_rd(4'b0010);
    fork
      mcmd(0, 1'b1, 32'h500, 8'd2, 64'h0);
      mcmd(1, 1'b1, 32'h600, 8'd2, 64'h0);
    join
    idle(6);

    // Eight outstanding reads fill the tag FIFO; the ninth waits for a return
    ret_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      push_cmd(1'b0, 32'h700 + 32'(k) * 8, 8'd1, 64'h0, -1);
      push_rd(4'b0001);
    end
    for (int k = 0; k < 8; k++) mcmd(0, 1'b1, 32'h700 + 32'(k) * 8, 8'd1, 64'h0);
    fork
      mcmd(0, 1'b1, 32'h740, 8'd1, 64'h0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("full_no_sread", 64'(s_read), 64'(0));
          chk("full_waitreq", 64'(m_waitrequest[0]), 64'(1));
        end
        ret_en = 1'b1;
      end
    join
    idle(14);

    // All four masters stream 16 single writes: strict 0,1,2,3 rotation, every other cycle
    rst = 1'b1; idle(2); rst = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        push_cmd(1'b1, 32'h1000 + 32'(i) * 32'h100 + 32'(k) * 8, 8'd1, 64'hC0 + 64'(i * 16 + k),
                 c0 + 1 + 2 * (k * 4 + i));
    fork
      master_stream(0);
      master_stream(1);
      master_stream(2);
      master_stream(3);
    join
    idle(2);

    // Read data with nothing outstanding sets the sticky error and is not forwarded
    @(negedge clk); spur = 1'b1;
    @(negedge clk);
    chk("spur_no_rdv", 64'(m_readdatavalid), 64'(0));
    chk("spur_err_before", 64'(err), 64'(0));
    spur = 1'b0;
    @(negedge clk); chk("spur_err_set", 64'(err), 64'(1));
    @(negedge clk); chk("spur_err_sticky", 64'(err), 64'(1));

    // Reset in the middle of a write burst restores reset outputs and clears the error
    @(posedge clk); #1;
    c0 = cyc;
    push_cmd(1'b1, 32'h900, 8'd4, 64'hE0, c0 + 1);
    push_cmd(1'b1, 32'h900, 8'd4, 64'hE0, c0 + 2);
    m_address[2] = 32'h900; m_burstcount[2] = 8'd4; m_writedata[2] = 64'hE0;
    m_byteenable[2] = '1; m_write[2] = 1'b1;
    idle(3);
    rst = 1'b1;
    m_write[2] = 1'b0;
    #1;
    chk("midrst_waitreq", 64'(m_waitrequest), 64'hF);
    chk("midrst_s_write", 64'(s_write), 64'(0));
    chk("midrst_s_addr", 64'(s_address), 64'(0));
    chk("midrst_s_bc", 64'(s_burstcount), 64'(0));
    chk("midrst_s_wdata", s_writedata, 64'(0));
    chk("midrst_err", 64'(err), 64'(0));
    chk("midrst_rdv", 64'(m_readdatavalid), 64'(0));
    idle(2);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    chk("post_rst_waitreq", 64'(m_waitrequest), 64'hF);
    chk("post_rst_err", 64'(err), 64'(0));

    chk("exp_cmd_drained", 64'(exp_cmd.size()), 64'(0));
    chk("exp_rd_drained", 64'(exp_rd.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/avalon_mm_arbiter.md
# avalon_mm_arbiter

Round-robin, burst-aware arbiter sharing one Avalon-MM slave port (e.g. the kernel-sim global memory model) between NUM_MASTERS kernel load/store masters. Holds the grant for the full length of a write burst and routes returning read data to the issuing master in order, using a FIFO of outstanding read tags. Sits between the per-LSU Avalon-MM master ports and the single memory slave in the kernel simulation bench.

## Interface
- NUM_MASTERS, 4, number of requesting masters (≥2)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width
- BURST_COUNT_WIDTH, 8, burstcount width
- BYTE_ENABLE_WIDTH, DATA_WIDTH/8, byteenable width
- MAX_PENDING_READS, 8, depth of the outstanding-read tag FIFO (power of 2)

Ports (m_* are packed arrays indexed by master, [NUM_MASTERS-1:0][W-1:0]):
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- m_address / m_burstcount / m_writedata / m_byteenable  in  N×field width  master command fields
- m_read, m_write  in  N  master read/write requests
- m_waitrequest  out  N  per-master stall
- m_readdata  out  DATA_WIDTH  broadcast read data
- m_readdatavalid  out  N  per-master read data strobe
- s_address / s_burstcount / s_writedata / s_byteenable  out  field width  slave command fields
- s_read, s_write  out  1  slave requests
- s_waitrequest  in  1  slave stall
- s_readdata  in  DATA_WIDTH; s_readdatavalid  in  1
- err_unexpected_rdata  out  1  sticky: readdatavalid with no read outstanding

## Operation
- FSM: IDLE, CMD, WR_BURST.
- IDLE: request vector req[i] = m_read[i] | m_write[i]. Round-robin winner = first requester at or after rr_ptr (wrapping). Register grant_id, rr_ptr ← grant_id+1 (mod N), go CMD. No request → stay.
- CMD: granted master's fields/read/write forwarded to slave; m_waitrequest[grant_id] = s_waitrequest; all other m_waitrequest = 1.
  - Read accepted (s_read & !s_waitrequest): push {grant_id, burstcount} to tag FIFO → IDLE.
  - Write beat accepted, burstcount ≤ 1 → IDLE; else load beats_left = burstcount−1 → WR_BURST.
  - Tag FIFO full: s_read forced 0, granted master sees waitrequest=1 (writes unaffected).
  - Master drops both read and write in CMD → IDLE (no transfer).
- WR_BURST: grant locked; only m_write of grant_id forwarded, s_read=0; each accepted beat decrements beats_left; accepted beat with beats_left==1 → IDLE. Write deasserted mid-burst: hold, no timeout.
- burstcount 0 is treated as 1.
- Read return: head tag {id, len}; m_readdatavalid[id] = s_readdatavalid; rd_cnt increments per beat; beat rd_cnt==len−1 pops head and clears rd_cnt. Push and pop in same cycle legal, including when full.
- s_readdatavalid with FIFO empty: data dropped, err_unexpected_rdata ← 1 until reset.
- Outside CMD/WR_BURST: s_read=s_write=0, s_* data fields 0.

## Timing
- Reset (async assert, sync release): FSM IDLE, rr_ptr 0, FIFO empty, rd_cnt 0, err 0; m_waitrequest all 1, m_readdatavalid 0, s_read/s_write 0, s_* fields 0.
- Arbitration costs one cycle: single-beat command with s_waitrequest=0 occupies 2 cycles (IDLE, CMD); back-to-back commands from any masters issue every other cycle.
- Write burst of L beats, no stalls: L+1 cycles.
- Read data path fully combinational: m_readdata = s_readdata, m_readdatavalid same cycle as s_readdatavalid.
- Reset mid-burst/mid-read: all state discarded; in-flight read data after reset raises err.

## Structure
- Package avalon_mm_arb_pkg: state enum, tag struct {id, len}, ID width constant $clog2(NUM_MASTERS).
- Sub-module rd_tag_fifo: synchronous FIFO, push/pop/full/empty/head, depth MAX_PENDING_READS, same-cycle push+pop allowed.

## Test plan
- Masters 0,2 issue single writes same cycle after reset → master 0 granted first, master 2 next; s_write pulses in cycles 2 and 4.
- Master 1 write burstcount 4 while master 3 reads → master 3 waitrequest held for all 4 beats; s_read only after burst done.
- Masters 0,1 each read burstcount 2; slave returns 4 beats → m_readdatavalid = 0b0001,0b0001,0b0010,0b0010.
- MAX_PENDING_READS=8 reads with no return → 9th read stalled (s_read=0); one full return unblocks it.
- All 4 masters requesting continuously for 16 commands → each granted exactly 4 times in order 0,1,2,3.
- s_readdatavalid with no reads pending → err_unexpected_rdata=1, no m_readdatavalid; assert rst mid write burst → outputs at reset values, err cleared.
